// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op codes, FSM states and op classifiers.
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit MD result generator: {hi,lo} for mul/div, plus accumulate when MDU_MADD_EN.
// Division works on magnitudes so 0x80000000 / -1 needs no special case.
module mdu_calc
    import mdu_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [63:0] acc,
    output logic [63:0] res,
    output logic        div_zero
);

    logic        sgn;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvs;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign sgn   = op_is_signed(op);
    assign ext_a = sgn ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
    assign ext_b = sgn ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
    assign prod  = ext_a * ext_b;

    assign neg_a    = sgn & src_a[31];
    assign neg_b    = sgn & src_b[31];
    assign mag_a    = neg_a ? (32'd0 - src_a) : src_a;
    assign mag_b    = neg_b ? (32'd0 - src_b) : src_b;
    assign div_zero = (src_b == 32'd0);
    // Substitute a harmless divisor on /0; the controller discards that result.
    assign dvs      = div_zero ? 32'd1 : mag_b;
    assign q_mag    = mag_a / dvs;
    assign r_mag    = mag_a % dvs;
    assign quo      = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    assign rem      = neg_a ? (32'd0 - r_mag) : r_mag;

`ifdef MDU_MADD_EN
    always_comb begin
        res = '0;
        case (op)
            MULT, MULTU:  res = prod;
            DIV, DIVU:    res = {rem, quo};
            MADD, MADDU:  res = acc + prod;
            MSUB, MSUBU:  res = acc - prod;
            default:      res = '0;
        endcase
    end
`else
    logic unused_acc;
    assign unused_acc = ^acc;

    always_comb begin
        res = '0;
        case (op)
            MULT, MULTU:  res = prod;
            DIV, DIVU:    res = {rem, quo};
            default:      res = '0;
        endcase
    end
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// MD sequencer: accepts an issue from E, holds busy for the op latency, commits {hi,lo} on the edge busy falls.
// MTHI/MTLO write immediately; MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    function automatic logic op_defined(input md_op_e o);
`ifdef MDU_MADD_EN
        return o inside {MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU};
`else
        return o inside {MULT, MULTU, DIV, DIVU, MTHI, MTLO};
`endif
    endfunction

    md_op_e             op;
    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   lat;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_skip;
    logic               accept;
    logic               long_issue;
    logic [63:0]        res;
    logic               div_zero;

    assign op         = md_op_e'(md_op);
    assign accept     = start && !flush && (state == IDLE) && op_defined(op);
    assign long_issue = accept && (op != MTHI) && (op != MTLO);
    assign lat        = op_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
    assign busy       = (state == RUN);

    mdu_calc u_calc (
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .acc      ({hi, lo}),
        .res      (res),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (long_issue) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_skip <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            if (long_issue) begin
                cnt       <= lat;
                pend_hi   <= res[63:32];
                pend_lo   <= res[31:0];
                pend_skip <= op_is_div(op) && div_zero;
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
                // A divide by zero still runs the full period but leaves HI/LO alone.
                if ((cnt == CNT_W'(1)) && !pend_skip) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
            if (accept && (op == MTHI)) hi <= src_a;
            if (accept && (op == MTLO)) lo <= src_a;
        end
    end

    // The hazard unit must never let a second issue arrive while an op is in flight.
    always_ff @(posedge clk) begin
        assert (!(reset && start && (state == RUN)))
            else $warning("mdu_ctrl: start while busy ignored");
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed scenarios plus random ops against a 64-bit arithmetic model (honours MDU_MADD_EN).
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one issue, from the ISA rules on 64-bit integers.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, output int lat, output logic [31:0] nhi,
                         output logic [31:0] nlo);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, v;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        nhi = m_hi;
        nlo = m_lo;
        lat = 0;
        if (fl) return;
        case (op)
            4'd1: begin v = sa * sb; {nhi, nlo} = v; lat = MUL_N; end
            4'd2: begin v = ua * ub; {nhi, nlo} = v; lat = MUL_N; end
            4'd3: begin
                lat = DIV_N;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    v = q; nlo = v[31:0];
                    v = r; nhi = v[31:0];
                end
            end
            4'd4: begin
                lat = DIV_N;
                if (b != 0) begin nlo = a / b; nhi = a % b; end
            end
            4'd5: nhi = a;
            4'd6: nlo = a;
`ifdef MDU_MADD_EN
            4'd7:  begin v = {m_hi, m_lo} + 64'(sa * sb); {nhi, nlo} = v; lat = MUL_N; end
            4'd8:  begin v = {m_hi, m_lo} + ua * ub;      {nhi, nlo} = v; lat = MUL_N; end
            4'd9:  begin v = {m_hi, m_lo} - 64'(sa * sb); {nhi, nlo} = v; lat = MUL_N; end
            4'd10: begin v = {m_hi, m_lo} - ua * ub;      {nhi, nlo} = v; lat = MUL_N; end
`endif
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after busy has dropped.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input string tag);
        int lat, nbusy;
        logic [31:0] ehi, elo;
        model(op, a, b, fl, lat, ehi, elo);
        start = 1'b1; md_op = op; src_a = a; src_b = b; flush = fl;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; md_op = 4'd0;
        nbusy = 0;
        for (int k = 0; k < 40 && busy === 1'b1; k++) begin
            chk({tag, "_hold_hi"}, hi, m_hi);
            chk({tag, "_hold_lo"}, lo, m_lo);
            nbusy++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, nbusy, lat);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        int lat, nbusy;
        logic [31:0] ehi, elo, a, b;
        logic [3:0] op;
        logic fl;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, "mult");
        chk("mult_hi_const", hi, 32'hFFFFFFFF);
        chk("mult_lo_const", lo, 32'hFFFFFFFE);
        issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, "multu");
        chk("multu_hi_const", hi, 32'd1);
        chk("multu_lo_const", lo, 32'hFFFFFFFE);

        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
        chk("div_neg_lo_const", lo, 32'hFFFFFFFD);
        chk("div_neg_hi_const", hi, 32'hFFFFFFFF);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        chk("div_ovf_lo_const", lo, 32'h80000000);
        chk("div_ovf_hi_const", hi, 32'd0);

        issue(4'd5, 32'h11, 32'd0, 1'b0, "mthi");
        issue(4'd6, 32'h22, 32'd0, 1'b0, "mtlo");
        issue(4'd3, 32'd1234, 32'd0, 1'b0, "div_zero");
        chk("div_zero_hi_const", hi, 32'h11);
        chk("div_zero_lo_const", lo, 32'h22);

        issue(4'd1, 32'd7, 32'd9, 1'b1, "flush_mult");
        chk("flush_mult_lo_const", lo, 32'h22);
        issue(4'd6, 32'h5, 32'd0, 1'b1, "flush_mtlo");
        chk("flush_mtlo_lo_const", lo, 32'h22);
        issue(4'd12, 32'd3, 32'd3, 1'b0, "undef_op");

        // Stray start during RUN must not disturb the running MULT.
        model(4'd1, 32'd1000, 32'd3000, 1'b0, lat, ehi, elo);
        start = 1'b1; md_op = 4'd1; src_a = 32'd1000; src_b = 32'd3000;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 40 && busy === 1'b1; k++) begin
            if (nbusy == 2) begin
                start = 1'b1; md_op = 4'd4; src_a = 32'd100; src_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            nbusy++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("stray_busy_cycles", nbusy, lat);
        chk("stray_hi", hi, ehi);
        chk("stray_lo", lo, elo);
        m_hi = ehi; m_lo = elo;
        @(negedge clk);
        chk("stray_no_second_op", busy, 1'b0);

        // Reset asserted during the third busy cycle of a DIV.
        start = 1'b1; md_op = 4'd3; src_a = 32'd99; src_b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_busy_before", busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        chk("rst_mid_no_commit_busy", busy, 1'b0);
        chk("rst_mid_no_commit_hi", hi, 32'd0);
        chk("rst_mid_no_commit_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        issue(4'd5, 32'd0, 32'd0, 1'b0, "madd_pre_hi");
        issue(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, "madd_pre_lo");
        issue(4'd8, 32'd1, 32'd1, 1'b0, "maddu");
`ifdef MDU_MADD_EN
        chk("maddu_hi_const", hi, 32'd1);
        chk("maddu_lo_const", lo, 32'd0);
`else
        chk("maddu_hi_const", hi, 32'd0);
        chk("maddu_lo_const", lo, 32'hFFFFFFFF);
`endif

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            fl = ($urandom_range(0, 7) == 0);
            issue(op, a, b, fl, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
